// File: rtl/key_event_decoder_if.sv
// rtl/key_event_decoder_if.sv - key event FIFO pop interface (valid/ready head plus overflow pulse)
interface key_event_decoder_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_code;
  logic       ev_ovf;

  modport master (
    output ev_valid,
    output ev_code,
    output ev_ovf,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_code,
    input  ev_ovf,
    output ev_ready
  );
endinterface

// File: rtl/key_event_decoder.sv
// rtl/key_event_decoder.sv - classifies key presses as SHORT/DOUBLE/LONG into a 4-entry event FIFO
// Optional auto-repeat of LONG while held: define KEY_REPEAT_EN.
module key_event_decoder #(
  parameter int LONG_CNT    = 50_000_000,
  parameter int DBL_GAP_CNT = 12_500_000,
  parameter int REPEAT_CNT  = 10_000_000,
  parameter int CNT_W       = 26
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       key_n,
  key_event_decoder_if.master        ev
);

  localparam logic [1:0] CODE_SHORT  = 2'b01;
  localparam logic [1:0] CODE_DOUBLE = 2'b10;
  localparam logic [1:0] CODE_LONG   = 2'b11;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_CNT - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CNT - 1);
`endif

  // Timer compares against count-1, so every count must fit in CNT_W bits.
  if (longint'(LONG_CNT) > (longint'(1) << CNT_W) ||
      longint'(DBL_GAP_CNT) > (longint'(1) << CNT_W) ||
      longint'(REPEAT_CNT) > (longint'(1) << CNT_W)) begin : g_cnt_w_check
    $error("CNT_W too narrow for the configured counts");
  end

  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG_HELD} state_t;

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic             key_d;
  logic             press_edge;
  logic             release_edge;
  logic             push;
  logic [1:0]       push_code;

  logic [1:0]       mem [4];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  logic [2:0]       count;
  logic             ovf_q;
  logic             full;
  logic             pop;
  logic             push_ok;

  assign press_edge   = key_d & ~key_n;
  assign release_edge = ~key_d & key_n;

  always_comb begin
    push      = 1'b0;
    push_code = 2'b00;
    case (state)
      PRESS1: if (!release_edge && timer == LONG_LAST) begin
        push      = 1'b1;
        push_code = CODE_LONG;
      end
      WAIT2: if (!press_edge && timer == GAP_LAST) begin
        push      = 1'b1;
        push_code = CODE_SHORT;
      end
      PRESS2: if (release_edge) begin
        push      = 1'b1;
        push_code = CODE_DOUBLE;
      end
`ifdef KEY_REPEAT_EN
      LONG_HELD: if (!release_edge && timer == REP_LAST) begin
        push      = 1'b1;
        push_code = CODE_LONG;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      key_d <= 1'b1;
    end else begin
      key_d <= key_n;
      case (state)
        IDLE: if (press_edge) begin
          state <= PRESS1;
          timer <= '0;
        end
        PRESS1: begin
          if (release_edge) begin
            state <= WAIT2;
            timer <= '0;
          end else if (timer == LONG_LAST) begin
            state <= LONG_HELD;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT2: begin
          // A press arriving on the timeout cycle still makes a DOUBLE.
          if (press_edge) begin
            state <= PRESS2;
            timer <= '0;
          end else if (timer == GAP_LAST) begin
            state <= IDLE;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        PRESS2: if (release_edge) begin
          state <= IDLE;
          timer <= '0;
        end
        LONG_HELD: begin
          if (release_edge) begin
            state <= IDLE;
            timer <= '0;
          end
`ifdef KEY_REPEAT_EN
          else if (timer == REP_LAST) begin
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
`endif
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  assign full    = (count == 3'd4);
  assign pop     = ev.ev_valid & ev.ev_ready;
  // When full, a simultaneous pop frees the slot the push is about to fill.
  assign push_ok = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ovf_q <= push & full & ~pop;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign ev.ev_valid = (count != 3'd0);
  assign ev.ev_code  = ev.ev_valid ? mem[rd_ptr] : 2'b00;
  assign ev.ev_ovf   = ovf_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// tb/tb_key_event_decoder.sv - directed self-checking bench for key_event_decoder
module tb_key_event_decoder;
  logic clk = 1'b0;
  logic rst;
  logic key_n;

  key_event_decoder_if ev_if();

  key_event_decoder #(
    .LONG_CNT    (20),
    .DBL_GAP_CNT (10),
    .REPEAT_CNT  (8),
    .CNT_W       (26)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_n),
    .ev    (ev_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int ovf_cnt  = 0;
  int log_q[$];

  // Record every accepted event and every overflow pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (ev_if.ev_valid && ev_if.ev_ready) log_q.push_back(int'(ev_if.ev_code));
      if (ev_if.ev_ovf) ovf_cnt++;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_short();
    key_n = 1'b0;
    tick(2);
    key_n = 1'b1;
    tick(14);
  endtask

  task automatic press_double();
    key_n = 1'b0;
    tick(2);
    key_n = 1'b1;
    tick(2);
    key_n = 1'b0;
    tick(2);
    key_n = 1'b1;
    tick(4);
  endtask

  task automatic press_long();
    key_n = 1'b0;
    tick(22);
    key_n = 1'b1;
    tick(4);
  endtask

  initial begin
    rst            = 1'b1;
    key_n          = 1'b1;
    ev_if.ev_ready = 1'b1;
    tick(3);
    check("reset_valid", int'(ev_if.ev_valid), 0);
    check("reset_code",  int'(ev_if.ev_code),  0);
    check("reset_ovf",   int'(ev_if.ev_ovf),   0);
    rst = 1'b0;
    tick(2);

    // Short press: WAIT2 entered cycle 6, event visible cycle 16
    log_q.delete();
    ovf_cnt = 0;
    key_n = 1'b0;
    tick(5);
    key_n = 1'b1;
    tick(10);
    check("short_not_yet", int'(ev_if.ev_valid), 0);
    tick(1);
    check("short_valid", int'(ev_if.ev_valid), 1);
    check("short_code",  int'(ev_if.ev_code),  1);
    tick(5);
    check("short_count",   log_q.size(), 1);
    check("short_after",   int'(ev_if.ev_valid), 0);
    check("short_no_ovf",  ovf_cnt, 0);

    // Double press: event 1 cycle after second release, no SHORT
    log_q.delete();
    key_n = 1'b0;
    tick(5);
    key_n = 1'b1;
    tick(4);
    key_n = 1'b0;
    tick(3);
    key_n = 1'b1;
    check("dbl_not_yet", int'(ev_if.ev_valid), 0);
    tick(1);
    check("dbl_valid", int'(ev_if.ev_valid), 1);
    check("dbl_code",  int'(ev_if.ev_code),  2);
    tick(15);
    check("dbl_count", log_q.size(), 1);

    // Long press held 40 cycles
    log_q.delete();
    key_n = 1'b0;
    tick(20);
    check("long_not_yet", int'(ev_if.ev_valid), 0);
    tick(1);
    check("long_valid", int'(ev_if.ev_valid), 1);
    check("long_code",  int'(ev_if.ev_code),  3);
    tick(19);
    key_n = 1'b1;
    tick(15);
`ifdef KEY_REPEAT_EN
    check("long_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      check("long_rep1", log_q[1], 3);
      check("long_rep2", log_q[2], 3);
    end
`else
    check("long_count", log_q.size(), 1);
`endif

    // Five SHORTs with consumer stalled: four queued, one dropped
    log_q.delete();
    ovf_cnt = 0;
    ev_if.ev_ready = 1'b0;
    for (int i = 0; i < 4; i++) press_short();
    check("fill_valid", int'(ev_if.ev_valid), 1);
    check("fill_hold",  int'(ev_if.ev_code),  1);
    check("fill_ovf0",  ovf_cnt, 0);
    press_short();
    check("fill_ovf1",  ovf_cnt, 1);
    ev_if.ev_ready = 1'b1;
    tick(8);
    check("drain_count", log_q.size(), 4);
    for (int i = 0; i < log_q.size(); i++) check($sformatf("drain_%0d", i), log_q[i], 1);
    check("drain_empty", int'(ev_if.ev_valid), 0);

    // Full FIFO, push coincides with pop: nothing lost, order kept
    log_q.delete();
    ovf_cnt = 0;
    ev_if.ev_ready = 1'b0;
    press_double();
    press_long();
    press_short();
    press_short();
    key_n = 1'b0;
    tick(2);
    key_n = 1'b1;
    tick(10);
    ev_if.ev_ready = 1'b1;
    tick(1);
    ev_if.ev_ready = 1'b0;
    check("pp_next_head", int'(ev_if.ev_code), 3);
    tick(4);
    check("pp_no_ovf", ovf_cnt, 0);
    ev_if.ev_ready = 1'b1;
    tick(6);
    check("pp_count", log_q.size(), 5);
    if (log_q.size() == 5) begin
      check("pp_0", log_q[0], 2);
      check("pp_1", log_q[1], 3);
      check("pp_2", log_q[2], 1);
      check("pp_3", log_q[3], 1);
      check("pp_4", log_q[4], 1);
    end
    check("pp_empty", int'(ev_if.ev_valid), 0);

    // Reset mid-press with a queued event; key held through reset release
    log_q.delete();
    ev_if.ev_ready = 1'b0;
    press_short();
    check("rst_pre_valid", int'(ev_if.ev_valid), 1);
    key_n = 1'b0;
    tick(5);
    rst = 1'b1;
    #1;
    check("rst_valid", int'(ev_if.ev_valid), 0);
    check("rst_code",  int'(ev_if.ev_code),  0);
    check("rst_ovf",   int'(ev_if.ev_ovf),   0);
    tick(2);
    rst = 1'b0;
    tick(3);
    key_n = 1'b1;
    ev_if.ev_ready = 1'b1;
    tick(14);
    check("rst_count", log_q.size(), 1);
    if (log_q.size() == 1) check("rst_code_after", log_q[0], 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
